processor_control_unit: RTL and testbench

//  Control FSM for the 16-bit simple processor datapath (register file R0-R7, A, G, ALU, shared bus).

---
 rtl/processor_control_unit_if.sv | 30 +++
 rtl/processor_control_unit.sv | 105 ++++++++++
 tb/tb_processor_control_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/processor_control_unit_if.sv
// Handshake/strobe bundle between the processor wrapper/datapath and the control unit.
// Control unit takes the slave side; wrapper or bench takes the master side.
interface processor_control_unit_if #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
);
    logic [DATA_W-1:0] Din;
    logic              run;
    logic [DATA_W-1:0] ir;
    logic              IRin;
    logic [NREG-1:0]   Rin;
    logic [NREG-1:0]   Rout;
    logic              DINout;
    logic              Gout;
    logic              Ain;
    logic              Gin;
    logic [1:0]        alu_op;
    logic              busy;
    logic              done;

    modport master (
        output Din, run,
        input  ir, IRin, Rin, Rout, DINout, Gout, Ain, Gin, alu_op, busy, done
    );

    modport slave (
        input  Din, run,
        output ir, IRin, Rin, Rout, DINout, Gout, Ain, Gin, alu_op, busy, done
    );
endinterface

// File: rtl/processor_control_unit.sv
// Purpose: T0..T3 control FSM for the simple 16-bit processor; decodes IR into datapath strobes.
// Latency: run->done 2 cycles for mv/mvi/illegal, 4 cycles for add/sub/and.
// Backpressure: none; run is only sampled in T0, so a held run fetches back-to-back.
module processor_control_unit #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input logic                    clock,
    input logic                    reset,
    processor_control_unit_if.slave cu
);
    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;

    localparam logic [3:0] OP_MV  = 4'd0;
    localparam logic [3:0] OP_MVI = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;

    state_t            state;
    logic [DATA_W-1:0] ir_q;
    logic [3:0]        opcode;
    logic [2:0]        rx;
    logic [2:0]        ry;
    logic [NREG-1:0]   rx_hot;
    logic [NREG-1:0]   ry_hot;
    logic              is_alu;

    assign opcode = ir_q[DATA_W-1 -: 4];
    assign rx     = ir_q[DATA_W-5 -: 3];
    assign ry     = ir_q[DATA_W-8 -: 3];
    assign rx_hot = {{(NREG-1){1'b0}}, 1'b1} << rx;
    assign ry_hot = {{(NREG-1){1'b0}}, 1'b1} << ry;
    assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND);
    assign cu.ir  = ir_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= T0;
            ir_q  <= '0;
        end else begin
            case (state)
                T0: if (cu.run) begin
                        ir_q  <= cu.Din;
                        state <= T1;
                    end
                T1: state <= is_alu ? T2 : T0;
                T2: state <= T3;
                default: state <= T0;
            endcase
        end
    end

    // Strobes are decoded from the current step so the datapath sees them in the same cycle;
    // reset forces them all low so an abandoned instruction can never write a register.
    always_comb begin
        cu.IRin   = 1'b0;
        cu.Rin    = '0;
        cu.Rout   = '0;
        cu.DINout = 1'b0;
        cu.Gout   = 1'b0;
        cu.Ain    = 1'b0;
        cu.Gin    = 1'b0;
        cu.alu_op = 2'b00;
        cu.busy   = 1'b0;
        cu.done   = 1'b0;
        if (!reset) begin
            case (state)
                T0: cu.IRin = cu.run;
                T1: begin
                    cu.busy = 1'b1;
                    if (opcode == OP_MV) begin
                        cu.Rout = ry_hot;
                        cu.Rin  = rx_hot;
                        cu.done = 1'b1;
                    end else if (opcode == OP_MVI) begin
                        cu.DINout = 1'b1;
                        cu.Rin    = rx_hot;
                        cu.done   = 1'b1;
                    end else if (is_alu) begin
                        cu.Rout = rx_hot;
                        cu.Ain  = 1'b1;
                    end else begin
                        cu.done = 1'b1;
                    end
                end
                T2: begin
                    cu.busy = 1'b1;
                    cu.Rout = ry_hot;
                    cu.Gin  = 1'b1;
                    if (opcode == OP_SUB)
                        cu.alu_op = 2'b01;
                    else if (opcode == OP_AND)
                        cu.alu_op = 2'b10;
                end
                default: begin
                    cu.busy = 1'b1;
                    cu.Gout = 1'b1;
                    cu.Rin  = rx_hot;
                    cu.done = 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_processor_control_unit.sv
// Bench for processor_control_unit: a toy datapath driven by the DUT strobes plus an
// instruction-level model that expands each fetched word into its expected per-step strobe list.
module tb_processor_control_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    processor_control_unit_if #(.DATA_W(16), .NREG(8)) cu ();

    processor_control_unit #(.DATA_W(16), .NREG(8)) dut (
        .clock (clock),
        .reset (reset),
        .cu    (cu)
    );

    always #5 clock = ~clock;

    // Toy datapath: register file, A, G and the shared bus, all steered by the DUT.
    logic [15:0] dp_r [8] = '{default: 16'h0};
    logic [15:0] dp_a = 16'h0;
    logic [15:0] dp_g = 16'h0;
    logic [15:0] bus;

    always_comb begin
        bus = 16'h0;
        for (int k = 0; k < 8; k++)
            if (cu.Rout[k]) bus = bus | dp_r[k];
        if (cu.DINout) bus = bus | cu.Din;
        if (cu.Gout)   bus = bus | dp_g;
    end

    always @(posedge clock) begin
        if (cu.Ain) dp_a <= bus;
        if (cu.Gin) begin
            case (cu.alu_op)
                2'b00:   dp_g <= dp_a + bus;
                2'b01:   dp_g <= dp_a - bus;
                2'b10:   dp_g <= dp_a & bus;
                default: dp_g <= 16'hxxxx;
            endcase
        end
        for (int k = 0; k < 8; k++)
            if (cu.Rin[k]) dp_r[k] <= bus;
    end

    // Model state: architectural registers, last fetched word, pending strobe steps.
    logic [15:0] m_r [8] = '{default: 16'h0};
    logic [15:0] m_ir = 16'h0;
    logic [24:0] q [$];
    logic [24:0] o;

    function automatic logic [24:0] pk(input logic irin, input logic [7:0] rin, input logic [7:0] rout,
                                       input logic dinout, input logic gout, input logic ain,
                                       input logic gin, input logic [1:0] op, input logic busy,
                                       input logic done);
        return {irin, rin, rout, dinout, gout, ain, gin, op, busy, done};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic issue(input logic [15:0] d);
        logic [3:0] opc;
        logic [7:0] hx, hy;
        opc = d[15:12];
        hx  = 8'd1 << d[11:9];
        hy  = 8'd1 << d[8:6];
        case (opc)
            4'd0: q.push_back(pk(0, hx, hy, 0, 0, 0, 0, 2'd0, 1, 1));
            4'd1: q.push_back(pk(0, hx, 8'h0, 1, 0, 0, 0, 2'd0, 1, 1));
            4'd2, 4'd3, 4'd4: begin
                q.push_back(pk(0, 8'h0, hx, 0, 0, 1, 0, 2'd0, 1, 0));
                q.push_back(pk(0, 8'h0, hy, 0, 0, 0, 1, 2'(opc - 4'd2), 1, 0));
                q.push_back(pk(0, hx, 8'h0, 0, 1, 0, 0, 2'd0, 1, 1));
            end
            default: q.push_back(pk(0, 8'h0, 8'h0, 0, 0, 0, 0, 2'd0, 1, 1));
        endcase
    endtask

    task automatic commit(input logic [15:0] din);
        logic [2:0] rx, ry;
        rx = m_ir[11:9];
        ry = m_ir[8:6];
        case (m_ir[15:12])
            4'd0: m_r[rx] = m_r[ry];
            4'd1: m_r[rx] = din;
            4'd2: m_r[rx] = m_r[rx] + m_r[ry];
            4'd3: m_r[rx] = m_r[rx] - m_r[ry];
            4'd4: m_r[rx] = m_r[rx] & m_r[ry];
            default: ;
        endcase
    endtask

    // One clock cycle: check registers, drive inputs, compare strobes, advance the model.
    task automatic step(input logic r, input logic [15:0] d, input logic rs);
        logic [127:0] ra, rm;
        logic [24:0]  exp, s;
        @(negedge clock);
        ra = '0;
        rm = '0;
        for (int k = 0; k < 8; k++) begin
            ra = {ra[111:0], dp_r[k]};
            rm = {rm[111:0], m_r[k]};
        end
        chk("regfile", ra, rm);
        reset  = rs;
        cu.run = r;
        cu.Din = d;
        #1;
        o = {cu.IRin, cu.Rin, cu.Rout, cu.DINout, cu.Gout, cu.Ain, cu.Gin, cu.alu_op, cu.busy, cu.done};
        if (rs)
            exp = '0;
        else if (q.size() == 0)
            exp = pk(r, 8'h0, 8'h0, 0, 0, 0, 0, 2'd0, 0, 0);
        else
            exp = q[0];
        chk("strobes", 128'(o), 128'(exp));
        chk("ir", 128'(cu.ir), 128'(m_ir));
        if (rs) begin
            q.delete();
            m_ir = 16'h0;
        end else if (q.size() == 0) begin
            if (r) begin
                m_ir = d;
                issue(d);
            end
        end else begin
            s = q.pop_front();
            if (s[0]) commit(d);
        end
    endtask

    initial begin
        logic [15:0] d;
        logic [3:0]  opc;
        logic        r, rs;
        int          sel;
        cu.run = 1'b0;
        cu.Din = 16'h0;
        @(posedge clock);

        step(0, 16'h0, 1);
        step(0, 16'h0, 1);
        chk("reset_outs", 128'(o), 128'(0));
        chk("reset_ir", 128'(cu.ir), 128'(0));

        step(1, 16'h1000, 0);
        chk("mvi_t0", 128'(o), 128'(pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 0, 0)));
        step(0, 16'h0005, 0);
        chk("mvi_t1", 128'(o), 128'(pk(0, 8'h01, 8'h00, 1, 0, 0, 0, 2'd0, 1, 1)));
        step(0, 16'h0, 0);
        chk("r0_is_5", 128'(dp_r[0]), 128'(16'd5));

        step(1, 16'h0600, 0);
        step(0, 16'hABCD, 0);
        chk("mv_t1", 128'(o), 128'(pk(0, 8'h08, 8'h01, 0, 0, 0, 0, 2'd0, 1, 1)));
        step(0, 16'h0, 0);
        chk("r3_is_5", 128'(dp_r[3]), 128'(16'd5));

        step(1, 16'h1200, 0);
        step(0, 16'h0007, 0);
        step(1, 16'h1400, 0);
        step(0, 16'h0003, 0);
        step(1, 16'h3280, 0);
        step(0, 16'h1111, 0);
        chk("sub_t1", 128'(o), 128'(pk(0, 8'h00, 8'h02, 0, 0, 1, 0, 2'd0, 1, 0)));
        step(1, 16'h2222, 0);
        chk("sub_t2", 128'(o), 128'(pk(0, 8'h00, 8'h04, 0, 0, 0, 1, 2'b01, 1, 0)));
        step(0, 16'h3333, 0);
        chk("sub_t3", 128'(o), 128'(pk(0, 8'h02, 8'h00, 0, 1, 0, 0, 2'd0, 1, 1)));
        step(0, 16'h0, 0);
        chk("r1_is_4", 128'(dp_r[1]), 128'(16'd4));

        step(1, 16'h2640, 0);
        step(1, 16'h5555, 0);
        step(1, 16'h6666, 0);
        step(1, 16'h7777, 0);
        chk("b2b_done", 128'(o[0]), 128'(1));
        step(1, 16'h1A00, 0);
        chk("b2b_irin", 128'(o), 128'(pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 0, 0)));
        step(1, 16'h0009, 0);
        step(0, 16'h0, 0);
        chk("r3_is_9", 128'(dp_r[3]), 128'(16'd9));
        chk("r5_is_9", 128'(dp_r[5]), 128'(16'd9));

        step(1, 16'h2480, 0);
        step(0, 16'h0, 0);
        chk("rst_mid_t1", 128'(o), 128'(pk(0, 8'h00, 8'h04, 0, 0, 1, 0, 2'd0, 1, 0)));
        step(0, 16'h0, 1);
        chk("rst_mid_outs", 128'(o), 128'(0));
        step(0, 16'h0, 0);
        chk("rst_mid_idle", 128'(o), 128'(0));
        step(0, 16'h0, 0);
        chk("r2_kept", 128'(dp_r[2]), 128'(16'd3));

        step(1, 16'hF000, 0);
        step(1, 16'h1234, 0);
        chk("illegal_t1", 128'(o), 128'(pk(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 1, 1)));
        step(0, 16'h0, 0);

        for (int i = 0; i < 3000; i++) begin
            rs = ($urandom_range(0, 49) == 0);
            if (q.size() == 0) begin
                r   = ($urandom_range(0, 3) != 0);
                sel = $urandom_range(0, 5);
                opc = (sel < 5) ? 4'(sel) : 4'($urandom_range(5, 15));
                d   = {opc, 12'($urandom)};
            end else begin
                r = 1'($urandom);
                d = 16'($urandom);
            end
            step(r, d, rs);
        end
        step(0, 16'h0, 0);
        step(0, 16'h0, 0);
        step(0, 16'h0, 0);
        step(0, 16'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
